// File: rtl/dram_pkg.sv
// Shared types for the open-page DRAM command scheduler: command codes,
// scheduler states and a constant max() helper for timing parameters.
package dram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_PR,
    CMD_PRA,
    CMD_RD,
    CMD_WR,
    CMD_REF
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_PRE_WAIT,
    S_ACT,
    S_ACT_WAIT,
    S_COL,
    S_RPRA,
    S_RPRA_WAIT,
    S_RREF,
    S_RREF_WAIT
  } state_e;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bank_state_table.sv
// Per-bank open flag, open row and precharge-legal countdown, indexed by {bg,ba}.
// One index serves both the lookup and the update strobes.
module bank_state_table
  import dram_pkg::*;
#(
  parameter int IW     = 4,
  parameter int RWIDTH = 16,
  parameter int T_RAS  = 32,
  parameter int T_WR   = 14,
  parameter int T_RDPR = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              act_stb,
  input  logic              rd_stb,
  input  logic              wr_stb,
  input  logic              pr_stb,
  input  logic              pra_stb,
  input  logic [IW-1:0]     idx,
  input  logic [RWIDTH-1:0] act_row,
  output logic              look_open,
  output logic [RWIDTH-1:0] look_row,
  output logic              look_pr_ready,
  output logic              any_open,
  output logic              all_pr_ready
);

  localparam int NB = 1 << IW;
  localparam int PW = $clog2(max(T_RAS, max(T_WR, T_RDPR)) + 1);

  logic [NB-1:0]     open_vec;
  logic [NB-1:0]     pr_zero_vec;
  logic [RWIDTH-1:0] row_arr [NB];

  for (genvar gi = 0; gi < NB; gi++) begin : g_bank
    logic              sel;
    logic              open_reg;
    logic [RWIDTH-1:0] row_reg;
    logic [PW-1:0]     pr_cnt_reg;
    logic [PW-1:0]     pr_cnt_dec;
    logic [PW-1:0]     pr_cnt_next;

    assign sel = (idx == IW'(gi));

    // The strobe cycle itself counts, so PR becomes legal exactly T cycles after it.
    always_comb begin
      pr_cnt_dec  = (pr_cnt_reg == '0) ? '0 : pr_cnt_reg - 1'b1;
      pr_cnt_next = pr_cnt_dec;
      if (sel && act_stb) begin
        pr_cnt_next = PW'(T_RAS - 1);
      end else if (sel && wr_stb && (pr_cnt_dec < PW'(T_WR - 1))) begin
        pr_cnt_next = PW'(T_WR - 1);
      end else if (sel && rd_stb && (pr_cnt_dec < PW'(T_RDPR - 1))) begin
        pr_cnt_next = PW'(T_RDPR - 1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        open_reg   <= 1'b0;
        row_reg    <= '0;
        pr_cnt_reg <= '0;
      end else begin
        pr_cnt_reg <= pr_cnt_next;
        if (pra_stb || (sel && pr_stb)) begin
          open_reg <= 1'b0;
        end else if (sel && act_stb) begin
          open_reg <= 1'b1;
          row_reg  <= act_row;
        end
      end
    end

    assign open_vec[gi]    = open_reg;
    assign pr_zero_vec[gi] = (pr_cnt_reg == '0);
    assign row_arr[gi]     = row_reg;
  end

  assign look_open     = open_vec[idx];
  assign look_row      = row_arr[idx];
  assign look_pr_ready = pr_zero_vec[idx];
  assign any_open      = |open_vec;
  assign all_pr_ready  = &(~open_vec | pr_zero_vec);

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Open-page command scheduler: turns one request at a time into ACT/PR/RD/WR
// pulses under tRCD/tRP/tRAS/tWR/tRTP/tRFC, with periodic PRA+REF refresh.
module dram_cmd_scheduler
  import dram_pkg::*;
#(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int RWIDTH  = 16,
  parameter int BL      = 8,
  parameter int T_RCD   = 15,
  parameter int T_RP    = 16,
  parameter int T_RAS   = 32,
  parameter int T_WR    = 14,
  parameter int T_RTP   = 7,
  parameter int T_RFC   = 34,
  parameter int T_REFI  = 7800
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [BGWIDTH-1:0] req_bg,
  input  logic [BAWIDTH-1:0] req_ba,
  input  logic [RWIDTH-1:0]  req_row,
  output logic               req_done,
  output logic               ACT,
  output logic               PR,
  output logic               PRA,
  output logic               RD,
  output logic               WR,
  output logic               REF,
  output logic [BGWIDTH-1:0] bg,
  output logic [BAWIDTH-1:0] ba,
  output logic [RWIDTH-1:0]  row,
  output logic               ref_busy
);

  localparam int IW     = BGWIDTH + BAWIDTH;
  localparam int T_RDPR = max(BL, T_RTP);
  localparam int WW     = max(1, $clog2(max(T_RCD, max(T_RP, T_RFC))));
  localparam int RFW    = $clog2(T_REFI + 1);

  state_e             state_reg, state_next;
  cmd_e               cmd;
  logic [WW-1:0]      wait_cnt_reg;
  logic [RFW-1:0]     ref_cnt_reg;
  logic               ref_pending_reg;
  logic               lat_write_reg;
  logic [BGWIDTH-1:0] lat_bg_reg, hold_bg_reg;
  logic [BAWIDTH-1:0] lat_ba_reg, hold_ba_reg;
  logic [RWIDTH-1:0]  lat_row_reg, hold_row_reg;
  logic [IW-1:0]      idx;
  logic               look_open, look_pr_ready, any_open, all_pr_ready;
  logic [RWIDTH-1:0]  look_row;
  logic               handshake, wait_done, ref_done, bank_cmd;

  // In IDLE the table is probed with the incoming request; otherwise with the latched one.
  assign idx       = (state_reg == S_IDLE) ? {req_bg, req_ba} : {lat_bg_reg, lat_ba_reg};
  assign req_ready = (state_reg == S_IDLE) && !ref_pending_reg && !reset;
  assign handshake = req_valid && req_ready;
  assign wait_done = (wait_cnt_reg <= WW'(1));
  assign ref_done  = (state_reg == S_RREF_WAIT) && wait_done;

  bank_state_table #(
    .IW(IW), .RWIDTH(RWIDTH), .T_RAS(T_RAS), .T_WR(T_WR), .T_RDPR(T_RDPR)
  ) u_banks (
    .clk          (clk),
    .reset        (reset),
    .act_stb      (cmd == CMD_ACT),
    .rd_stb       (cmd == CMD_RD),
    .wr_stb       (cmd == CMD_WR),
    .pr_stb       (cmd == CMD_PR),
    .pra_stb      (cmd == CMD_PRA),
    .idx          (idx),
    .act_row      (lat_row_reg),
    .look_open    (look_open),
    .look_row     (look_row),
    .look_pr_ready(look_pr_ready),
    .any_open     (any_open),
    .all_pr_ready (all_pr_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (ref_pending_reg) begin
          state_next = any_open ? S_RPRA : S_RREF;
        end else if (handshake) begin
          if (!look_open)               state_next = S_ACT;
          else if (look_row == req_row) state_next = S_COL;
          else                          state_next = S_PRE;
        end
      end
      S_PRE:       if (look_pr_ready) state_next = S_PRE_WAIT;
      S_PRE_WAIT:  if (wait_done)     state_next = S_ACT;
      S_ACT:                          state_next = S_ACT_WAIT;
      S_ACT_WAIT:  if (wait_done)     state_next = S_COL;
      S_COL:                          state_next = S_IDLE;
      S_RPRA:      if (all_pr_ready)  state_next = S_RPRA_WAIT;
      S_RPRA_WAIT: if (wait_done)     state_next = S_RREF;
      S_RREF:                         state_next = S_RREF_WAIT;
      S_RREF_WAIT: if (wait_done)     state_next = S_IDLE;
      default:                        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd = CMD_NOP;
    case (state_reg)
      S_PRE:   if (look_pr_ready) cmd = CMD_PR;
      S_ACT:   cmd = CMD_ACT;
      S_COL:   cmd = lat_write_reg ? CMD_WR : CMD_RD;
      S_RPRA:  if (all_pr_ready) cmd = CMD_PRA;
      S_RREF:  cmd = CMD_REF;
      default: cmd = CMD_NOP;
    endcase
  end

  assign ACT      = (cmd == CMD_ACT);
  assign PR       = (cmd == CMD_PR);
  assign PRA      = (cmd == CMD_PRA);
  assign RD       = (cmd == CMD_RD);
  assign WR       = (cmd == CMD_WR);
  assign REF      = (cmd == CMD_REF);
  assign req_done = RD || WR;
  assign ref_busy = ref_pending_reg;
  assign bank_cmd = ACT || PR || RD || WR;
  assign bg       = bank_cmd ? lat_bg_reg  : hold_bg_reg;
  assign ba       = bank_cmd ? lat_ba_reg  : hold_ba_reg;
  assign row      = ACT      ? lat_row_reg : hold_row_reg;

  // A wait state lasts T-1 cycles so the next command lands T cycles after the pulse.
  always_ff @(posedge clk) begin
    if (reset)                          wait_cnt_reg <= '0;
    else if (PR || PRA)                 wait_cnt_reg <= WW'(T_RP - 1);
    else if (ACT)                       wait_cnt_reg <= WW'(T_RCD - 1);
    else if (REF)                       wait_cnt_reg <= WW'(T_RFC - 1);
    else if (wait_cnt_reg != '0)        wait_cnt_reg <= wait_cnt_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_reg     <= RFW'(T_REFI);
      ref_pending_reg <= 1'b0;
    end else if (ref_cnt_reg == '0) begin
      ref_cnt_reg     <= RFW'(T_REFI);
      ref_pending_reg <= 1'b1;
    end else begin
      ref_cnt_reg <= ref_cnt_reg - 1'b1;
      if (ref_done) ref_pending_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write_reg <= 1'b0;
      lat_bg_reg    <= '0;
      lat_ba_reg    <= '0;
      lat_row_reg   <= '0;
      hold_bg_reg   <= '0;
      hold_ba_reg   <= '0;
      hold_row_reg  <= '0;
    end else begin
      if (handshake) begin
        lat_write_reg <= req_write;
        lat_bg_reg    <= req_bg;
        lat_ba_reg    <= req_ba;
        lat_row_reg   <= req_row;
      end
      if (bank_cmd) begin
        hold_bg_reg <= lat_bg_reg;
        hold_ba_reg <= lat_ba_reg;
      end
      if (ACT) hold_row_reg <= lat_row_reg;
    end
  end

endmodule
